// File: rtl/dff_rlm_pkg.sv
// Shared types for the DFF run-length monitor; the long-run split option (DFF_RLM_SPLIT_EN) is applied in the top.
package dff_rlm_pkg;

    localparam int RLM_CNT_W = 8;
    localparam int LEN_MAX   = (1 << RLM_CNT_W) - 1;

    typedef struct packed {
        logic                 run_bit;
        logic                 run_sat;
        logic [RLM_CNT_W-1:0] run_len;
    } rlm_rec_t;

    typedef enum logic {
        S_IDLE,
        S_COUNT
    } state_t;

endpackage

// File: rtl/rlm_fifo.sv
// Synchronous record FIFO with a registered head; a pop on a full FIFO frees the slot for a same-cycle push.
module rlm_fifo
    import dff_rlm_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type rec_t = rlm_rec_t
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  rec_t wr_rec,
    input  logic pop,
    output logic full,
    output logic empty,
    output rec_t head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    rec_t        mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] rd_nxt;
    logic        do_pop;
    logic        do_push;

    // Extra pointer bit separates full (MSBs differ) from empty (pointers equal).
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_nxt  = do_pop ? rd_ptr + PTR_ONE : rd_ptr;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wr_rec;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            head   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            rd_ptr <= rd_nxt;
            // Forward the incoming record when it becomes the new head; hold when draining to empty.
            if (do_push && (wr_ptr == rd_nxt)) begin
                head <= wr_rec;
            end else if (rd_nxt != wr_ptr) begin
                head <= mem[rd_nxt[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/dff_run_length_monitor.sv
// Recovers (value, hold length) runs from a sampled bit stream and queues them on a valid/ready output.
// Build option DFF_RLM_SPLIT_EN reports over-long holds as full-scale chunks instead of one saturated record.
module dff_run_length_monitor
    import dff_rlm_pkg::*;
#(
    parameter int CNT_W      = RLM_CNT_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    output logic             run_valid,
    input  logic             run_ready,
    output logic             run_bit,
    output logic [CNT_W-1:0] run_len,
    output logic             run_sat,
    output logic             drop
);

    typedef struct packed {
        logic             run_bit;
        logic             run_sat;
        logic [CNT_W-1:0] run_len;
    } rec_t;

    localparam logic [CNT_W-1:0] LEN_CAP = '1;

    state_t           state;
    logic             cur_bit;
    logic [CNT_W-1:0] count;
    logic             sat;
    logic             at_cap;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    rec_t             push_rec;
    rec_t             head;

    assign at_cap = (count == LEN_CAP);

    always_comb begin
        push     = 1'b0;
        push_rec = '{run_bit: cur_bit, run_sat: sat, run_len: count};
        if (state == S_COUNT) begin
            if (din != cur_bit) begin
                push = 1'b1;
`ifdef DFF_RLM_SPLIT_EN
            end else if (at_cap) begin
                push             = 1'b1;
                push_rec.run_sat = 1'b1;
`endif
            end
        end
    end

    assign run_valid = !empty;
    assign pop       = run_valid && run_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cur_bit <= 1'b0;
            count   <= '0;
            sat     <= 1'b0;
            drop    <= 1'b0;
        end else begin
            if (push && full && !pop) begin
                drop <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    cur_bit <= din;
                    count   <= CNT_W'(1);
                    sat     <= 1'b0;
                    state   <= S_COUNT;
                end
                S_COUNT: begin
                    // A push always closes the current record and starts a new one with this sample.
                    if (push) begin
                        cur_bit <= din;
                        count   <= CNT_W'(1);
                        sat     <= 1'b0;
                    end else if (at_cap) begin
                        sat <= 1'b1;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    rlm_fifo #(
        .DEPTH (FIFO_DEPTH),
        .rec_t (rec_t)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (push),
        .wr_rec (push_rec),
        .pop    (pop),
        .full   (full),
        .empty  (empty),
        .head   (head)
    );

    assign run_bit = head.run_bit;
    assign run_len = head.run_len;
    assign run_sat = head.run_sat;

endmodule

// File: tb/tb_dff_run_length_monitor.sv
// Directed and randomized bench for dff_run_length_monitor, scored against a run-length reference model.
module tb_dff_run_length_monitor;

    localparam int CNT_W = 4;
    localparam int DEPTH = 4;
    localparam int CAP   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             din = 1'b0;
    logic             run_ready = 1'b0;
    logic             run_valid;
    logic             run_bit;
    logic [CNT_W-1:0] run_len;
    logic             run_sat;
    logic             drop;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit b;
        int len;
        bit sat;
    } rec_s;

    rec_s exp_q[$];
    bit   m_drop = 1'b0;
    bit   m_run  = 1'b0;
    bit   m_cur  = 1'b0;
    int   m_len  = 0;

    dff_run_length_monitor #(
        .CNT_W      (CNT_W),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .run_valid (run_valid),
        .run_ready (run_ready),
        .run_bit   (run_bit),
        .run_len   (run_len),
        .run_sat   (run_sat),
        .drop      (drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: m_len is the true hold length so far; records are derived from it arithmetically.
    task automatic model(input bit r, input bit d, input bit rdy);
        rec_s rec;
        bit   have;
        bit   pop;
        have = 1'b0;
        rec  = '{b: 1'b0, len: 0, sat: 1'b0};
        if (r) begin
            exp_q.delete();
            m_drop = 1'b0;
            m_run  = 1'b0;
            m_len  = 0;
            return;
        end
        pop = (exp_q.size() > 0) && rdy;
        if (!m_run) begin
            m_run = 1'b1;
            m_cur = d;
            m_len = 1;
        end else if (d != m_cur) begin
`ifdef DFF_RLM_SPLIT_EN
            rec = '{b: m_cur, len: m_len - CAP * ((m_len - 1) / CAP), sat: 1'b0};
`else
            rec = '{b: m_cur, len: (m_len > CAP) ? CAP : m_len, sat: (m_len > CAP)};
`endif
            have  = 1'b1;
            m_cur = d;
            m_len = 1;
        end else begin
            m_len++;
`ifdef DFF_RLM_SPLIT_EN
            if ((m_len % CAP) == 1) begin
                rec  = '{b: m_cur, len: CAP, sat: 1'b1};
                have = 1'b1;
            end
`endif
        end
        if (pop) begin
            void'(exp_q.pop_front());
        end
        if (have) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(rec);
            else m_drop = 1'b1;
        end
    endtask

    task automatic check_outputs();
        chk("run_valid", 32'(run_valid), 32'(exp_q.size() > 0));
        if (exp_q.size() > 0) begin
            chk("run_bit", 32'(run_bit), 32'(exp_q[0].b));
            chk("run_len", 32'(run_len), 32'(exp_q[0].len));
            chk("run_sat", 32'(run_sat), 32'(exp_q[0].sat));
        end
        chk("drop", 32'(drop), 32'(m_drop));
    endtask

    task automatic check_reset();
        chk("rst_valid", 32'(run_valid), 32'd0);
        chk("rst_bit",   32'(run_bit),   32'd0);
        chk("rst_len",   32'(run_len),   32'd0);
        chk("rst_sat",   32'(run_sat),   32'd0);
        chk("rst_drop",  32'(drop),      32'd0);
    endtask

    task automatic step(input bit r, input bit d, input bit rdy);
        rst       = r;
        din       = d;
        run_ready = rdy;
        model(r, d, rdy);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic hold(input bit d, input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, d, rdy);
    endtask

    initial begin
        bit b;
        int len;

        // Basic runs with a ready consumer
        step(1'b1, 1'b0, 1'b1);
        check_reset();
        hold(1'b0, 3, 1'b1);
        hold(1'b1, 5, 1'b1);
        hold(1'b0, 2, 1'b1);
        hold(1'b1, 3, 1'b1);

        // Backpressure: six edges into a four-deep FIFO, then drain
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) hold(1'(i % 2), 2, 1'b0);
        chk("bp_drop_set", 32'(drop), 32'd1);
        chk("bp_head_len", 32'(run_len), 32'd2);
        hold(1'b0, 6, 1'b1);
        chk("bp_drained", 32'(run_valid), 32'd0);
        chk("bp_drop_sticky", 32'(drop), 32'd1);

        // Full FIFO: an edge coincides with a pop
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) hold(1'(i % 2), 2, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        chk("full_pop_push_nodrop", 32'(drop), 32'd0);
        hold(1'b1, 3, 1'b0);
        hold(1'b0, 8, 1'b1);

        // Saturation / chunking of a 20-cycle hold
        step(1'b1, 1'b0, 1'b1);
        hold(1'b0, 2, 1'b1);
        hold(1'b1, 20, 1'b1);
        hold(1'b0, 4, 1'b1);

        // Reset mid-run discards the partial run
        step(1'b1, 1'b0, 1'b1);
        hold(1'b1, 7, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        check_reset();
        hold(1'b1, 2, 1'b1);
        hold(1'b0, 4, 1'b1);

        // Single-cycle runs
        step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b0, 1'(i % 2), 1'b1);

        // Randomized holds, readiness and occasional reset
        b = 1'b0;
        for (int r = 0; r < 80; r++) begin
            b   = ~b;
            len = ($urandom_range(0, 4) == 0) ? $urandom_range(14, 40) : $urandom_range(1, 6);
            for (int c = 0; c < len; c++) begin
                if ($urandom_range(0, 199) == 0) step(1'b1, b, 1'b1);
                else step(1'b0, b, ($urandom_range(0, 3) != 0));
            end
        end
        hold(~b, 12, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
